// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the multi-channel memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } chan_state_e;

  localparam int ADDR_BITS_DEFAULT = 8;
  localparam int DEPTH             = 2 ** ADDR_BITS_DEFAULT;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One valid/ready channel: fixed-latency handshake FSM with address/data capture.
module mem_channel_fsm
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int CNT_W     = $clog2(LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  output logic                 commit,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] cap_addr,
  output logic [DATA_BITS-1:0] cap_data
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  chan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 commit_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    addr_d   = addr_q;
    data_d   = data_q;
    commit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = addr_in;
          data_d  = data_in;
        end
      end
      WAIT: begin
        // Dropping valid before the response aborts without touching the array.
        if (!valid) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          commit_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (!valid) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign ready    = ready_q;
  assign commit   = commit_d;
  assign busy     = (state_q != IDLE);
  assign cap_addr = addr_q;
  assign cap_data = data_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel fixed-latency memory target backed by a register array with host preload.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CHANNELS  = 4,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              host_write_enable,
  input  logic [ADDR_BITS-1:0]              host_address,
  input  logic [DATA_BITS-1:0]              host_write_data,
  output logic [DATA_BITS-1:0]              host_read_data,
  output logic                              busy
);

  localparam int ARR_DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W     = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);

  logic [DATA_BITS-1:0] mem_q [ARR_DEPTH];
  logic [DATA_BITS-1:0] mem_d [ARR_DEPTH];

  logic [NUM_CHANNELS-1:0] rd_commit, wr_commit, rd_busy, wr_busy;
  logic [ADDR_BITS-1:0]    rd_addr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    wr_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wr_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rd_cap_data_unused [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rd_data_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rd_data_d [NUM_CHANNELS];

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    mem_channel_fsm #(
      .LATENCY  (READ_LATENCY),
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .CNT_W    (CNT_W)
    ) u_rd (
      .clk     (clk),
      .reset   (reset),
      .valid   (mem_read_valid[i]),
      .addr_in (mem_read_address[i*ADDR_BITS +: ADDR_BITS]),
      .data_in ('0),
      .ready   (mem_read_ready[i]),
      .commit  (rd_commit[i]),
      .busy    (rd_busy[i]),
      .cap_addr(rd_addr[i]),
      .cap_data(rd_cap_data_unused[i])
    );

    mem_channel_fsm #(
      .LATENCY  (WRITE_LATENCY),
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .CNT_W    (CNT_W)
    ) u_wr (
      .clk     (clk),
      .reset   (reset),
      .valid   (mem_write_valid[i]),
      .addr_in (mem_write_address[i*ADDR_BITS +: ADDR_BITS]),
      .data_in (mem_write_data[i*DATA_BITS +: DATA_BITS]),
      .ready   (mem_write_ready[i]),
      .commit  (wr_commit[i]),
      .busy    (wr_busy[i]),
      .cap_addr(wr_addr[i]),
      .cap_data(wr_data[i])
    );

    assign mem_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
  end

  // Host first, then channels in ascending order so the highest index wins a conflict.
  always_comb begin
    mem_d = mem_q;
    if (host_write_enable) begin
      mem_d[host_address] = host_write_data;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wr_commit[i]) begin
        mem_d[wr_addr[i]] = wr_data[i];
      end
    end
  end

  // Reads sample the pre-edge array, so a same-edge write returns the old value.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rd_data_d[i] = rd_commit[i] ? mem_q[rd_addr[i]] : rd_data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '{default: '0};
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign host_read_data = mem_q[host_address];
  assign busy           = (|rd_busy) | (|wr_busy);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, handshake, priority, abort and reset.
module tb_mem_responder;

  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     mem_read_valid;
  logic [NC*AB-1:0]  mem_read_address;
  logic [NC-1:0]     mem_read_ready;
  logic [NC*DB-1:0]  mem_read_data;
  logic [NC-1:0]     mem_write_valid;
  logic [NC*AB-1:0]  mem_write_address;
  logic [NC*DB-1:0]  mem_write_data;
  logic [NC-1:0]     mem_write_ready;
  logic              host_write_enable;
  logic [AB-1:0]     host_address;
  logic [DB-1:0]     host_write_data;
  logic [DB-1:0]     host_read_data;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS    (AB),
    .DATA_BITS    (DB),
    .NUM_CHANNELS (NC),
    .READ_LATENCY (2),
    .WRITE_LATENCY(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready),
    .host_write_enable(host_write_enable),
    .host_address     (host_address),
    .host_write_data  (host_write_data),
    .host_read_data   (host_read_data),
    .busy             (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int ch, input logic v, input logic [AB-1:0] a);
    mem_read_valid[ch]             = v;
    mem_read_address[ch*AB +: AB]  = a;
  endtask

  task automatic set_wr(input int ch, input logic v, input logic [AB-1:0] a, input logic [DB-1:0] d);
    mem_write_valid[ch]             = v;
    mem_write_address[ch*AB +: AB]  = a;
    mem_write_data[ch*DB +: DB]     = d;
  endtask

  task automatic host_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
    host_write_enable = 1'b1;
    host_address      = a;
    host_write_data   = d;
    step();
    host_write_enable = 1'b0;
  endtask

  function automatic logic [DB-1:0] rdata(input int ch);
    return mem_read_data[ch*DB +: DB];
  endfunction

  task automatic test_reset();
    reset             = 1'b1;
    mem_read_valid    = '0;
    mem_read_address  = '0;
    mem_write_valid   = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    host_write_enable = 1'b0;
    host_address      = 8'h10;
    host_write_data   = '0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (mem_read_ready !== 4'b0000 || mem_write_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got rd=%b wr=%b want 0000", mem_read_ready, mem_write_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (mem_read_data !== 64'h0 || host_read_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got rd=%h peek=%h want 0", mem_read_data, host_read_data);
    end
  endtask

  task automatic test_preload_read();
    host_write(8'h10, 16'h1234);
    checks++;
    if (host_read_data !== 16'h1234) begin
      failures++;
      $display("FAIL preload_peek got=%h want=1234", host_read_data);
    end
    set_rd(0, 1'b1, 8'h10);
    step();
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL read_early got ready=%b busy=%b want ready=0 busy=1", mem_read_ready[0], busy);
    end
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b1 || rdata(0) !== 16'h1234) begin
      failures++;
      $display("FAIL read_latency got ready=%b data=%h want 1 1234", mem_read_ready[0], rdata(0));
    end
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b1 || rdata(0) !== 16'h1234) begin
      failures++;
      $display("FAIL read_hold got ready=%b data=%h want 1 1234", mem_read_ready[0], rdata(0));
    end
    set_rd(0, 1'b0, 8'h00);
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b0 || rdata(0) !== 16'h1234 || busy !== 1'b0) begin
      failures++;
      $display("FAIL read_release got ready=%b data=%h busy=%b want 0 1234 0", mem_read_ready[0], rdata(0), busy);
    end
  endtask

  task automatic test_write_read();
    set_wr(1, 1'b1, 8'h05, 16'h7FFF);
    step();
    step();
    checks++;
    if (mem_write_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL write_early got=%b want=0", mem_write_ready[1]);
    end
    step();
    checks++;
    if (mem_write_ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL write_ready got=%b want=1", mem_write_ready[1]);
    end
    set_wr(1, 1'b0, 8'h00, 16'h0000);
    step();
    checks++;
    if (mem_write_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL write_release got=%b want=0", mem_write_ready[1]);
    end
    host_address = 8'h05;
    #1;
    checks++;
    if (host_read_data !== 16'h7FFF) begin
      failures++;
      $display("FAIL write_peek got=%h want=7fff", host_read_data);
    end
    set_rd(2, 1'b1, 8'h05);
    step();
    step();
    step();
    checks++;
    if (mem_read_ready[2] !== 1'b1 || rdata(2) !== 16'h7FFF) begin
      failures++;
      $display("FAIL write_readback got ready=%b data=%h want 1 7fff", mem_read_ready[2], rdata(2));
    end
    set_rd(2, 1'b0, 8'h00);
    step();
  endtask

  task automatic test_conflict();
    set_wr(0, 1'b1, 8'h20, 16'h1111);
    set_wr(3, 1'b1, 8'h20, 16'h3333);
    step();
    step();
    step();
    checks++;
    if (mem_write_ready !== 4'b1001) begin
      failures++;
      $display("FAIL conflict_ready got=%b want=1001", mem_write_ready);
    end
    set_wr(0, 1'b0, 8'h00, 16'h0000);
    set_wr(3, 1'b0, 8'h00, 16'h0000);
    host_address = 8'h20;
    step();
    checks++;
    if (host_read_data !== 16'h3333) begin
      failures++;
      $display("FAIL conflict_winner got=%h want=3333", host_read_data);
    end
  endtask

  task automatic test_all_channels();
    logic [DB-1:0] exp;
    for (int i = 0; i < NC; i++) host_write(AB'(i), DB'(16'hA0 + i));
    for (int i = 0; i < NC; i++) set_rd(i, 1'b1, AB'(i));
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (busy !== 1'b1 || mem_read_ready !== 4'b0000) begin
        failures++;
        $display("FAIL concurrent_wait%0d got busy=%b ready=%b want 1 0000", c, busy, mem_read_ready);
      end
    end
    step();
    checks++;
    if (busy !== 1'b1 || mem_read_ready !== 4'b1111) begin
      failures++;
      $display("FAIL concurrent_ready got busy=%b ready=%b want 1 1111", busy, mem_read_ready);
    end
    for (int i = 0; i < NC; i++) begin
      exp = DB'(16'hA0 + i);
      checks++;
      if (rdata(i) !== exp) begin
        failures++;
        $display("FAIL concurrent_data ch%0d got=%h want=%h", i, rdata(i), exp);
      end
    end
    mem_read_valid = '0;
    step();
    checks++;
    if (busy !== 1'b0 || mem_read_ready !== 4'b0000) begin
      failures++;
      $display("FAIL concurrent_release got busy=%b ready=%b want 0 0000", busy, mem_read_ready);
    end
  endtask

  task automatic test_abort();
    set_rd(1, 1'b1, 8'h10);
    step();
    set_rd(1, 1'b0, 8'h10);
    step();
    checks++;
    if (mem_read_ready[1] !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got ready=%b busy=%b want 0 0", mem_read_ready[1], busy);
    end
    step();
    checks++;
    if (mem_read_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_ready got=%b want=0", mem_read_ready[1]);
    end
    set_rd(1, 1'b1, 8'h10);
    step();
    step();
    checks++;
    if (mem_read_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL abort_retry_early got=%b want=0", mem_read_ready[1]);
    end
    step();
    checks++;
    if (mem_read_ready[1] !== 1'b1 || rdata(1) !== 16'h1234) begin
      failures++;
      $display("FAIL abort_retry got ready=%b data=%h want 1 1234", mem_read_ready[1], rdata(1));
    end
    set_rd(1, 1'b0, 8'h00);
    step();
  endtask

  task automatic test_read_during_write();
    host_write(8'h30, 16'h0042);
    set_rd(0, 1'b1, 8'h30);
    set_wr(0, 1'b1, 8'h30, 16'h5555);
    host_address = 8'h30;
    step();
    step();
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b1 || mem_write_ready[0] !== 1'b1 || rdata(0) !== 16'h0042) begin
      failures++;
      $display("FAIL rdw_old got rr=%b wr=%b data=%h want 1 1 0042", mem_read_ready[0], mem_write_ready[0], rdata(0));
    end
    checks++;
    if (host_read_data !== 16'h5555) begin
      failures++;
      $display("FAIL rdw_array got=%h want=5555", host_read_data);
    end
    set_rd(0, 1'b0, 8'h00);
    set_wr(0, 1'b0, 8'h00, 16'h0000);
    step();
  endtask

  task automatic test_reset_mid_op();
    set_rd(0, 1'b1, 8'h05);
    step();
    step();
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b1 || rdata(0) !== 16'h7FFF) begin
      failures++;
      $display("FAIL midrst_resp got ready=%b data=%h want 1 7fff", mem_read_ready[0], rdata(0));
    end
    reset        = 1'b1;
    host_address = 8'h05;
    step();
    checks++;
    if (mem_read_ready[0] !== 1'b0 || busy !== 1'b0 || rdata(0) !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_state got ready=%b busy=%b data=%h want 0 0 0000", mem_read_ready[0], busy, rdata(0));
    end
    checks++;
    if (host_read_data !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_array got=%h want=0000", host_read_data);
    end
    reset = 1'b0;
    set_rd(0, 1'b0, 8'h00);
    step();
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_conflict();
    test_all_channels();
    test_abort();
    test_read_during_write();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
